// File: rtl/md_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer feeding the HI/LO writeback path.
// MD_FAST_MULT_EN selects a single-cycle multiplier; divide stays iterative.
module md_sequencer #(
  parameter int MD_ITER = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        md_valid,
  input  logic [1:0]  md_op,
  input  logic [31:0] md_src1,
  input  logic [31:0] md_src2,
  input  logic        md_cancel,
  output logic        md_busy,
  output logic        md_double_en,
  output logic [63:0] md_result
);

  localparam int CW = $clog2(MD_ITER);
  localparam logic [CW-1:0] LAST = CW'(MD_ITER - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_div;
  logic          neg_lo;
  logic          neg_hi;
  logic          div0;
  logic [31:0]   opb;
  logic [31:0]   src1_q;
  logic [63:0]   acc;

  logic          accept;
  logic          sgn_op;
  logic          s1_neg;
  logic          s2_neg;
  logic [31:0]   mag1;
  logic [31:0]   mag2;
  logic [32:0]   mul_sum;
  logic [32:0]   div_part;
  logic [32:0]   div_diff;
  logic [63:0]   acc_next;
  logic [31:0]   hi_fix;
  logic [31:0]   lo_fix;
  logic [63:0]   fin;

  assign accept = md_valid & ~md_cancel & (state != CALC);
  assign md_busy = resetn & ((state == CALC) | accept);
  assign md_double_en = (state == DONE) & ~md_cancel;

  assign sgn_op = ~md_op[0];
  assign s1_neg = sgn_op & md_src1[31];
  assign s2_neg = sgn_op & md_src2[31];
  assign mag1 = s1_neg ? -md_src1 : md_src1;
  assign mag2 = s2_neg ? -md_src2 : md_src2;

`ifdef MD_FAST_MULT_EN
  logic [63:0] fx1;
  logic [63:0] fx2;
  logic [63:0] fast_prod;
  assign fx1 = {{32{s1_neg}}, md_src1};
  assign fx2 = {{32{s2_neg}}, md_src2};
  assign fast_prod = fx1 * fx2;
`endif

  // acc is {partial,multiplier} for MUL and {remainder,quotient} for DIV
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    div_part = {acc[63:32], acc[31]};
    div_diff = div_part - {1'b0, opb};
    acc_next = {mul_sum, acc[31:1]};
    if (is_div) begin
      if (div_diff[32])
        acc_next = {acc[62:0], 1'b0};
      else
        acc_next = {div_diff[31:0], acc[30:0], 1'b1};
    end
    hi_fix = neg_hi ? -acc_next[63:32] : acc_next[63:32];
    lo_fix = neg_lo ? -acc_next[31:0] : acc_next[31:0];
    if (div0)
      fin = {src1_q, 32'hFFFF_FFFF};
    else if (is_div)
      fin = {hi_fix, lo_fix};
    else
      fin = neg_lo ? -acc_next : acc_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      is_div    <= 1'b0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      div0      <= 1'b0;
      opb       <= '0;
      src1_q    <= '0;
      acc       <= '0;
      md_result <= '0;
    end else if (accept) begin
`ifdef MD_FAST_MULT_EN
      if (!md_op[1]) begin
        md_result <= fast_prod;
        state     <= DONE;
      end else
`endif
      begin
        state  <= CALC;
        cnt    <= '0;
        is_div <= md_op[1];
        neg_lo <= s1_neg ^ s2_neg;
        neg_hi <= s1_neg;
        div0   <= md_op[1] & (md_src2 == 32'd0);
        src1_q <= md_src1;
        opb    <= md_op[1] ? mag2 : mag1;
        acc    <= {32'd0, md_op[1] ? mag1 : mag2};
      end
    end else if (state == CALC) begin
      if (md_cancel) begin
        state <= IDLE;
      end else begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) begin
          md_result <= fin;
          state     <= DONE;
        end
      end
    end else begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer.
// Reference results come from plain 64-bit integer arithmetic.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        md_valid = 1'b0;
  logic [1:0]  md_op = 2'b00;
  logic [31:0] md_src1 = '0;
  logic [31:0] md_src2 = '0;
  logic        md_cancel = 1'b0;
  logic        md_busy;
  logic        md_double_en;
  logic [63:0] md_result;

  int errors = 0;
  int checks = 0;

  md_sequencer dut (
    .clk(clk),
    .resetn(resetn),
    .md_valid(md_valid),
    .md_op(md_op),
    .md_src1(md_src1),
    .md_src2(md_src2),
    .md_cancel(md_cancel),
    .md_busy(md_busy),
    .md_double_en(md_double_en),
    .md_result(md_result)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(
    input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
    case (op)
      2'b00: r = 64'(sa * sb);
      2'b01: r = ua * ub;
      2'b10: begin
        longint q, m;
        q = sa / sb;
        m = sa % sb;
        r = {m[31:0], q[31:0]};
      end
      default: begin
        longint unsigned q, m;
        q = ua / ub;
        m = ua % ub;
        r = {m[31:0], q[31:0]};
      end
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [1:0] op);
`ifdef MD_FAST_MULT_EN
    if (!op[1]) return 1;
`endif
    return 33;
  endfunction

  task automatic present(
    input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    md_valid = 1'b1;
    md_op = op;
    md_src1 = a;
    md_src2 = b;
  endtask

  // Walk cycles from the issue cycle; returns at the negedge of the strobe.
  task automatic track(
    input int k0, input bit drop, output int lat, output int nbusy);
    lat = -1;
    nbusy = 0;
    for (int k = k0; k < 80; k++) begin
      @(negedge clk);
      if (md_busy) nbusy++;
      if (md_double_en) begin
        lat = k;
        return;
      end
      @(posedge clk);
      #1;
      if (drop && k == k0) md_valid = 1'b0;
    end
  endtask

  task automatic run_op(
    input string nm, input logic [1:0] op,
    input logic [31:0] a, input logic [31:0] b);
    int lat, nb, el;
    logic [63:0] exp;
    exp = model(op, a, b);
    el = exp_lat(op);
    present(op, a, b);
    track(0, 1'b1, lat, nb);
    checks++;
    if (lat !== el) begin
      errors++;
      $display("FAIL %s latency got=%0d want=%0d", nm, lat, el);
    end
    checks++;
    if (nb !== (el == 1 ? 1 : 33)) begin
      errors++;
      $display("FAIL %s busy_cycles got=%0d want=%0d", nm, nb,
               (el == 1 ? 1 : 33));
    end
    checks++;
    if (md_result !== exp) begin
      errors++;
      $display("FAIL %s result got=%h want=%h", nm, md_result, exp);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (md_double_en !== 1'b0 || md_result !== exp) begin
      errors++;
      $display("FAIL %s after_strobe dbl=%b res=%h want dbl=0 res=%h",
               nm, md_double_en, md_result, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    md_valid = 1'b1;
    md_op = 2'b01;
    #1;
    checks++;
    if (md_busy !== 1'b0 || md_double_en !== 1'b0 || md_result !== 64'h0) begin
      errors++;
      $display("FAIL reset busy=%b dbl=%b res=%h want 0/0/0",
               md_busy, md_double_en, md_result);
    end
    md_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'd3);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7);
    run_op("divu_by0", 2'b11, 32'd5, 32'd0);
    run_op("div_by0", 2'b10, 32'h8000_0000, 32'd0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      logic [1:0] op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) b = b & 32'hFF;
      run_op("random", op, a, b);
    end
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    logic [63:0] ea, eb;
    ea = model(2'b10, 32'hFFFF_F000, 32'd77);
    eb = model(2'b11, 32'hDEAD_BEEF, 32'd1234);
    present(2'b10, 32'hFFFF_F000, 32'd77);
    track(0, 1'b1, lat, nb);
    checks++;
    if (lat !== 33 || md_result !== ea) begin
      errors++;
      $display("FAIL b2b_first lat=%0d res=%h want 33 %h", lat, md_result, ea);
    end
    present(2'b11, 32'hDEAD_BEEF, 32'd1234);
    #1;
    checks++;
    if (md_busy !== 1'b1 || md_double_en !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept busy=%b dbl=%b want 1/1", md_busy, md_double_en);
    end
    @(posedge clk);
    #1;
    md_valid = 1'b0;
    track(1, 1'b0, lat, nb);
    checks++;
    if (lat !== 33 || nb !== 32 || md_result !== eb) begin
      errors++;
      $display("FAIL b2b_second lat=%0d busy=%0d res=%h want 33 32 %h",
               lat, nb, md_result, eb);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_cancel();
    logic [63:0] prev;
    int strobes, busy_n;
    prev = md_result;
    present(2'b11, 32'd1000, 32'd3);
    for (int k = 0; k < 11; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) md_valid = 1'b0;
    end
    md_cancel = 1'b1;
    @(negedge clk);
    checks++;
    if (md_double_en !== 1'b0) begin
      errors++;
      $display("FAIL cancel_strobe dbl=%b want 0", md_double_en);
    end
    @(posedge clk);
    #1;
    md_cancel = 1'b0;
    strobes = 0;
    busy_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (md_double_en) strobes++;
      if (md_busy) busy_n++;
    end
    checks++;
    if (strobes !== 0 || busy_n !== 0 || md_result !== prev) begin
      errors++;
      $display("FAIL cancel_after strobes=%0d busy=%0d res=%h want 0 0 %h",
               strobes, busy_n, md_result, prev);
    end
    @(posedge clk);
    #1;
    run_op("multu_3x4", 2'b01, 32'd3, 32'd4);
  endtask

  task automatic test_reset_mid();
    int strobes, busy_n;
    present(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) md_valid = 1'b0;
    end
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if (md_busy !== 1'b0 || md_double_en !== 1'b0 || md_result !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid busy=%b dbl=%b res=%h want 0/0/0",
               md_busy, md_double_en, md_result);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    strobes = 0;
    busy_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (md_double_en) strobes++;
      if (md_busy) busy_n++;
    end
    checks++;
    if (strobes !== 0 || busy_n !== 0 || md_result !== 64'h0) begin
      errors++;
      $display("FAIL reset_idle strobes=%0d busy=%0d res=%h want 0 0 0",
               strobes, busy_n, md_result);
    end
    @(posedge clk);
    #1;
    run_op("post_reset", 2'b00, 32'hFFFF_FF00, 32'h0000_0100);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_cancel();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
